// File: rtl/spi_arbiter_if.sv
// Bundle of requester-side and SPI-controller-side signals for spi_arbiter.
// The slave modport is the arbiter's view; master is the environment's view.
interface spi_arbiter_if;
    // requester side
    logic [1:0] req;
    logic [7:0] tx_data0;
    logic [7:0] tx_data1;
    logic [1:0] tx_last;
    logic [1:0] grant;
    logic [1:0] tx_ready;
    logic [1:0] rx_valid;
    logic [7:0] rx_data;
    logic       err;
    // SPI controller side
    logic       spi_start;
    logic [7:0] spi_data;
    logic       spi_hold_cs;
    logic       spi_done;
    logic [7:0] spi_data_received;

    modport slave (
        input  req, tx_data0, tx_data1, tx_last, spi_done, spi_data_received,
        output grant, tx_ready, rx_valid, rx_data, err, spi_start, spi_data, spi_hold_cs
    );

    modport master (
        output req, tx_data0, tx_data1, tx_last, spi_done, spi_data_received,
        input  grant, tx_ready, rx_valid, rx_data, err, spi_start, spi_data, spi_hold_cs
    );
endinterface

// File: rtl/spi_arbiter.sv
// Two-requester round-robin arbiter in front of a byte-wide SPI controller.
// Every output is a register; output values are computed from the next state
// so that pulses line up with the state they belong to (e.g. spi_start is
// high during the ISSUE cycle itself).
module spi_arbiter #(
    parameter int unsigned TIMEOUT_CYCLES = 4096
) (
    input  logic          clk,
    input  logic          rst,
    spi_arbiter_if.slave  bus
);

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_ISSUE   = 3'd1;
    localparam logic [2:0] S_WAIT    = 3'd2;
    localparam logic [2:0] S_ABORT   = 3'd3;
    localparam logic [2:0] S_RELEASE = 3'd4;

    localparam logic [15:0] CNT_LAST = 16'(TIMEOUT_CYCLES - 1);
    localparam logic [15:0] CNT_MAX  = 16'hFFFF;

    logic [2:0]  state_q, state_d;
    logic [1:0]  grant_q, grant_d;
    logic        ptr_q, ptr_d;
    logic [15:0] cnt_q, cnt_d;
    logic        last_q, last_d;
    logic        abort_q, abort_d;
    logic [1:0]  tx_ready_q, tx_ready_d;
    logic [1:0]  rx_valid_q, rx_valid_d;
    logic [7:0]  rx_data_q, rx_data_d;
    logic        err_q, err_d;
    logic        start_q, start_d;
    logic [7:0]  sdata_q, sdata_d;
    logic        hold_q, hold_d;

    logic        owner;
    logic        do_issue;
    logic        issue_idx;

    assign owner = grant_q[1];

    // Next-state and next-output computation for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        grant_d    = grant_q;
        ptr_d      = ptr_q;
        cnt_d      = cnt_q;
        last_d     = last_q;
        abort_d    = abort_q;
        tx_ready_d = 2'b00;
        rx_valid_d = 2'b00;
        rx_data_d  = rx_data_q;
        err_d      = 1'b0;
        start_d    = 1'b0;
        sdata_d    = sdata_q;
        hold_d     = hold_q;
        do_issue   = 1'b0;
        issue_idx  = owner;

        case (state_q)
            S_IDLE: begin
                if (bus.req != 2'b00) begin
                    // both requesting: the pointer decides; otherwise the lone one
                    issue_idx = (bus.req == 2'b11) ? ptr_q : bus.req[1];
                    grant_d   = issue_idx ? 2'b10 : 2'b01;
                    do_issue  = 1'b1;
                    state_d   = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = 16'd0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (bus.spi_done) begin
                    rx_data_d  = bus.spi_data_received;
                    rx_valid_d = abort_q ? 2'b00 : grant_q;
                    if (last_q) begin
                        state_d = S_RELEASE;
                    end else if (bus.req[owner]) begin
                        issue_idx = owner;
                        do_issue  = 1'b1;
                        state_d   = S_ISSUE;
                    end else begin
                        // owner vanished mid-transaction: send a dummy byte that drops CS
                        start_d = 1'b1;
                        sdata_d = 8'h00;
                        hold_d  = 1'b0;
                        err_d   = 1'b1;
                        state_d = S_ABORT;
                    end
                end else if (cnt_q == CNT_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_RELEASE;
                end else if (cnt_q != CNT_MAX) begin
                    cnt_d = cnt_q + 16'd1;
                end
            end
            S_ABORT: begin
                cnt_d   = 16'd0;
                last_d  = 1'b1;
                abort_d = 1'b1;
                state_d = S_WAIT;
            end
            S_RELEASE: begin
                grant_d = 2'b00;
                ptr_d   = ~owner;
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
                grant_d = 2'b00;
            end
        endcase

        if (do_issue) begin
            tx_ready_d = issue_idx ? 2'b10 : 2'b01;
            start_d    = 1'b1;
            sdata_d    = issue_idx ? bus.tx_data1 : bus.tx_data0;
            hold_d     = ~bus.tx_last[issue_idx];
            last_d     = bus.tx_last[issue_idx];
            abort_d    = 1'b0;
        end
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= S_IDLE;
            grant_q    <= 2'b00;
            ptr_q      <= 1'b0;
            cnt_q      <= 16'd0;
            last_q     <= 1'b0;
            abort_q    <= 1'b0;
            tx_ready_q <= 2'b00;
            rx_valid_q <= 2'b00;
            rx_data_q  <= 8'h00;
            err_q      <= 1'b0;
            start_q    <= 1'b0;
            sdata_q    <= 8'h00;
            hold_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            grant_q    <= grant_d;
            ptr_q      <= ptr_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            abort_q    <= abort_d;
            tx_ready_q <= tx_ready_d;
            rx_valid_q <= rx_valid_d;
            rx_data_q  <= rx_data_d;
            err_q      <= err_d;
            start_q    <= start_d;
            sdata_q    <= sdata_d;
            hold_q     <= hold_d;
        end
    end

    assign bus.grant       = grant_q;
    assign bus.tx_ready    = tx_ready_q;
    assign bus.rx_valid    = rx_valid_q;
    assign bus.rx_data     = rx_data_q;
    assign bus.err         = err_q;
    assign bus.spi_start   = start_q;
    assign bus.spi_data    = sdata_q;
    assign bus.spi_hold_cs = hold_q;

endmodule

// File: tb/tb_spi_arbiter.sv
// Testbench for spi_arbiter: cycle-by-cycle vector table plus hand-written
// round-robin alternation and timeout sequences.
module tb_spi_arbiter;

    logic clk = 1'b0;
    logic rst = 1'b1;

    always #5 clk = ~clk;

    spi_arbiter_if bus ();

    spi_arbiter #(.TIMEOUT_CYCLES(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    typedef struct {
        string      name;
        logic       rst;
        logic [1:0] req;
        logic [7:0] d0;
        logic [7:0] d1;
        logic [1:0] last;
        logic       done;
        logic [7:0] rx;
        logic [1:0] e_grant;
        logic [1:0] e_rdy;
        logic [1:0] e_rxv;
        logic [7:0] e_rxd;
        logic       e_err;
        logic       e_start;
        logic [7:0] e_data;
        logic       e_hold;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    function automatic vec_t mk(string nm, logic r, logic [1:0] rq, logic [7:0] a, logic [7:0] b,
                                logic [1:0] l, logic dn, logic [7:0] rx,
                                logic [1:0] g, logic [1:0] rdy, logic [1:0] rxv, logic [7:0] rxd,
                                logic e, logic st, logic [7:0] sd, logic h);
        vec_t v;
        v.name = nm; v.rst = r; v.req = rq; v.d0 = a; v.d1 = b; v.last = l; v.done = dn; v.rx = rx;
        v.e_grant = g; v.e_rdy = rdy; v.e_rxv = rxv; v.e_rxd = rxd;
        v.e_err = e; v.e_start = st; v.e_data = sd; v.e_hold = h;
        return v;
    endfunction

    task automatic check(input string nm, input logic [7:0] act, input logic [7:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic drive(input logic r, input logic [1:0] rq, input logic [7:0] a, input logic [7:0] b,
                         input logic [1:0] l, input logic dn, input logic [7:0] rx);
        rst = r;
        bus.req = rq;
        bus.tx_data0 = a;
        bus.tx_data1 = b;
        bus.tx_last = l;
        bus.spi_done = dn;
        bus.spi_data_received = rx;
    endtask

    logic [1:0] grants[3];
    int         nstarts;
    logic       pend;
    logic       saw_err;
    int         ncyc;

    initial begin
        drive(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00);

        // single byte, with a request arriving during RELEASE
        vecs.push_back(mk("s_rst",  1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk("s_iss",  0, 2'b01, 8'hA5, 8'h00, 2'b01, 0, 8'h00, 2'b01, 2'b01, 2'b00, 8'h00, 0, 1, 8'hA5, 0));
        vecs.push_back(mk("s_wait", 0, 2'b00, 8'hA5, 8'h00, 2'b01, 0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 0, 0, 8'hA5, 0));
        vecs.push_back(mk("s_done", 0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 8'h3C, 2'b01, 2'b00, 2'b01, 8'h3C, 0, 0, 8'hA5, 0));
        vecs.push_back(mk("s_rel",  0, 2'b01, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h3C, 0, 0, 8'hA5, 0));
        vecs.push_back(mk("s_idle", 0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h3C, 0, 0, 8'hA5, 0));
        // contention from reset; spi_done in IDLE/ISSUE ignored
        vecs.push_back(mk("c_rst",  1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk("c_g0",   0, 2'b11, 8'h10, 8'h20, 2'b11, 1, 8'hEE, 2'b01, 2'b01, 2'b00, 8'h00, 0, 1, 8'h10, 0));
        vecs.push_back(mk("c_w0",   0, 2'b11, 8'h10, 8'h20, 2'b11, 1, 8'hEE, 2'b01, 2'b00, 2'b00, 8'h00, 0, 0, 8'h10, 0));
        vecs.push_back(mk("c_d0",   0, 2'b11, 8'h10, 8'h20, 2'b11, 1, 8'h55, 2'b01, 2'b00, 2'b01, 8'h55, 0, 0, 8'h10, 0));
        vecs.push_back(mk("c_r0",   0, 2'b11, 8'h10, 8'h20, 2'b11, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h55, 0, 0, 8'h10, 0));
        vecs.push_back(mk("c_g1",   0, 2'b11, 8'h10, 8'h20, 2'b11, 0, 8'h00, 2'b10, 2'b10, 2'b00, 8'h55, 0, 1, 8'h20, 0));
        vecs.push_back(mk("c_w1",   0, 2'b01, 8'h10, 8'h20, 2'b11, 0, 8'h00, 2'b10, 2'b00, 2'b00, 8'h55, 0, 0, 8'h20, 0));
        vecs.push_back(mk("c_d1",   0, 2'b01, 8'h10, 8'h20, 2'b11, 1, 8'h66, 2'b10, 2'b00, 2'b10, 8'h66, 0, 0, 8'h20, 0));
        vecs.push_back(mk("c_r1",   0, 2'b01, 8'h10, 8'h20, 2'b11, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h66, 0, 0, 8'h20, 0));
        // three-byte burst for requester 1, non-owner req toggling ignored
        vecs.push_back(mk("b_rst",  1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk("b_i1",   0, 2'b10, 8'h00, 8'h11, 2'b00, 0, 8'h00, 2'b10, 2'b10, 2'b00, 8'h00, 0, 1, 8'h11, 1));
        vecs.push_back(mk("b_w1",   0, 2'b10, 8'h00, 8'h22, 2'b00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 8'h00, 0, 0, 8'h11, 1));
        vecs.push_back(mk("b_d1",   0, 2'b10, 8'h00, 8'h22, 2'b00, 1, 8'hA1, 2'b10, 2'b10, 2'b10, 8'hA1, 0, 1, 8'h22, 1));
        vecs.push_back(mk("b_w2",   0, 2'b11, 8'h00, 8'h33, 2'b10, 0, 8'h00, 2'b10, 2'b00, 2'b00, 8'hA1, 0, 0, 8'h22, 1));
        vecs.push_back(mk("b_d2",   0, 2'b11, 8'h00, 8'h33, 2'b10, 1, 8'hA2, 2'b10, 2'b10, 2'b10, 8'hA2, 0, 1, 8'h33, 0));
        vecs.push_back(mk("b_w3",   0, 2'b01, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b10, 2'b00, 2'b00, 8'hA2, 0, 0, 8'h33, 0));
        vecs.push_back(mk("b_d3",   0, 2'b01, 8'h00, 8'h00, 2'b00, 1, 8'hA3, 2'b10, 2'b00, 2'b10, 8'hA3, 0, 0, 8'h33, 0));
        vecs.push_back(mk("b_rel",  0, 2'b01, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'hA3, 0, 0, 8'h33, 0));
        // abort: requester 0 drops req after first of two bytes
        vecs.push_back(mk("a_rst",  1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk("a_i1",   0, 2'b01, 8'hC1, 8'h00, 2'b00, 0, 8'h00, 2'b01, 2'b01, 2'b00, 8'h00, 0, 1, 8'hC1, 1));
        vecs.push_back(mk("a_w1",   0, 2'b00, 8'hC2, 8'h00, 2'b00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 0, 0, 8'hC1, 1));
        vecs.push_back(mk("a_ab",   0, 2'b00, 8'hC2, 8'h00, 2'b00, 1, 8'hD1, 2'b01, 2'b00, 2'b01, 8'hD1, 1, 1, 8'h00, 0));
        vecs.push_back(mk("a_w2",   0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 8'hD1, 0, 0, 8'h00, 0));
        vecs.push_back(mk("a_d2",   0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 8'hD2, 2'b01, 2'b00, 2'b00, 8'hD2, 0, 0, 8'h00, 0));
        vecs.push_back(mk("a_rel",  0, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'hD2, 0, 0, 8'h00, 0));
        // reset asserted during WAIT
        vecs.push_back(mk("r_rst",  1, 2'b00, 8'h00, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk("r_i1",   0, 2'b01, 8'hB7, 8'h00, 2'b00, 0, 8'h00, 2'b01, 2'b01, 2'b00, 8'h00, 0, 1, 8'hB7, 1));
        vecs.push_back(mk("r_w1",   0, 2'b01, 8'hB7, 8'h00, 2'b00, 0, 8'h00, 2'b01, 2'b00, 2'b00, 8'h00, 0, 0, 8'hB7, 1));
        vecs.push_back(mk("r_mid",  1, 2'b01, 8'hB7, 8'h00, 2'b00, 0, 8'h00, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));
        vecs.push_back(mk("r_idle", 0, 2'b00, 8'h00, 8'h00, 2'b00, 1, 8'h99, 2'b00, 2'b00, 2'b00, 8'h00, 0, 0, 8'h00, 0));

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].req, vecs[i].d0, vecs[i].d1, vecs[i].last, vecs[i].done, vecs[i].rx);
            @(posedge clk);
            #1;
            check({vecs[i].name, ".grant"},    8'(bus.grant),       8'(vecs[i].e_grant));
            check({vecs[i].name, ".tx_ready"}, 8'(bus.tx_ready),    8'(vecs[i].e_rdy));
            check({vecs[i].name, ".rx_valid"}, 8'(bus.rx_valid),    8'(vecs[i].e_rxv));
            check({vecs[i].name, ".rx_data"},  bus.rx_data,         vecs[i].e_rxd);
            check({vecs[i].name, ".err"},      8'(bus.err),         8'(vecs[i].e_err));
            check({vecs[i].name, ".start"},    8'(bus.spi_start),   8'(vecs[i].e_start));
            check({vecs[i].name, ".spi_data"}, bus.spi_data,        vecs[i].e_data);
            check({vecs[i].name, ".hold_cs"},  8'(bus.spi_hold_cs), 8'(vecs[i].e_hold));
        end

        // round-robin alternation with req=11 held and a controller answering each start
        drive(1'b1, 2'b00, 8'h10, 8'h20, 2'b11, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b11, 8'h10, 8'h20, 2'b11, 1'b0, 8'h5A);
        nstarts = 0;
        pend    = 1'b0;
        saw_err = 1'b0;
        for (int c = 0; c < 40 && nstarts < 3; c++) begin
            @(posedge clk);
            #1;
            bus.spi_done = pend;
            pend = 1'b0;
            if (bus.err) saw_err = 1'b1;
            if (bus.spi_start) begin
                grants[nstarts] = bus.grant;
                nstarts++;
                pend = 1'b1;
            end
        end
        bus.spi_done = 1'b0;
        check("rr.nstarts", 8'(nstarts), 8'd3);
        if (nstarts == 3) begin
            check("rr.grant0", 8'(grants[0]), 8'h01);
            check("rr.grant1", 8'(grants[1]), 8'h02);
            check("rr.grant2", 8'(grants[2]), 8'h01);
        end
        check("rr.no_err", 8'(saw_err), 8'd0);

        // timeout with TIMEOUT_CYCLES=8: err 8 cycles after WAIT entry, pointer advances
        drive(1'b1, 2'b00, 8'hE1, 8'hF1, 2'b11, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        drive(1'b0, 2'b01, 8'hE1, 8'hF1, 2'b11, 1'b0, 8'h00);
        @(posedge clk);
        #1;
        check("to.issue_grant", 8'(bus.grant), 8'h01);
        bus.req = 2'b00;
        @(posedge clk);
        #1;
        ncyc = 0;
        while (!bus.err && ncyc < 50) begin
            @(posedge clk);
            #1;
            ncyc++;
        end
        check("to.cycles", 8'(ncyc), 8'd8);
        check("to.err", 8'(bus.err), 8'd1);
        check("to.rx_valid", 8'(bus.rx_valid), 8'd0);
        check("to.grant_held", 8'(bus.grant), 8'h01);
        @(posedge clk);
        #1;
        check("to.released", 8'(bus.grant), 8'h00);
        check("to.err_once", 8'(bus.err), 8'd0);
        bus.req = 2'b11;
        @(posedge clk);
        #1;
        check("to.ptr_grant", 8'(bus.grant), 8'h02);
        check("to.ptr_data", bus.spi_data, 8'hF1);

        drive(1'b1, 2'b00, 8'h00, 8'h00, 2'b00, 1'b0, 8'h00);
        @(posedge clk);
        #1;

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/spi_arbiter.md
SPI_ARBITER -- requirements
Module: spi_arbiter

Interface
REQ-001 The block SHALL have parameter TIMEOUT_CYCLES, default 4096, meaning max cycles allowed in WAIT for spi_done; legal range 2..65535.
REQ-002 The block SHALL have port clk  input  1  system clock; all logic is on its rising edge.
REQ-003 The block SHALL have port rst  input  1  reset, synchronous and active-high.
REQ-004 The block SHALL have port req  input  2  per-requester bus request, held high until that requester's last byte is accepted.
REQ-005 The block SHALL have ports tx_data0 and tx_data1  input  8 each  byte to send for requester 0 and requester 1.
REQ-006 The block SHALL have port tx_last  input  2  per-requester flag: the presented byte ends the transaction.
REQ-007 The block SHALL have port grant  output  2  one-hot owner of the SPI controller, or 0 when none.
REQ-008 The block SHALL have port tx_ready  output  2  one-cycle pulse: the granted requester's byte is consumed this cycle.
REQ-009 The block SHALL have port rx_valid  output  2  one-cycle pulse to the owner: rx_data is valid.
REQ-010 The block SHALL have port rx_data  output  8  byte received for the last completed transfer.
REQ-011 The block SHALL have port err  output  1  one-cycle pulse on timeout or on abort.
REQ-012 The block SHALL have port spi_start  output  1  one-cycle pulse to the controller to start a byte.
REQ-013 The block SHALL have port spi_data  output  8  byte to the controller.
REQ-014 The block SHALL have port spi_hold_cs  output  1  keep chip-select asserted after this byte.
REQ-015 The block SHALL have port spi_done  input  1  controller pulse: one byte completed.
REQ-016 The block SHALL have port spi_data_received  input  8  controller receive byte, valid with spi_done.

Function
REQ-017 The FSM SHALL have states IDLE, ISSUE, WAIT, ABORT and RELEASE; all outputs SHALL be registered.
REQ-018 IDLE SHALL select on any req bit; when both are set, it selects the requester indexed by the 1-bit round-robin pointer, else the single requester; the next state is ISSUE.
REQ-019 grant SHALL rise in the cycle after the req sample and stay constant, one-hot, until RELEASE completes.
REQ-020 In ISSUE, for exactly 1 cycle, the block SHALL drive spi_start=1, tx_ready[g]=1, spi_data=tx_data of the owner, and spi_hold_cs=!tx_last[g]; it SHALL latch tx_last[g], then go to WAIT.
REQ-021 In WAIT, the block SHALL count cycles from 0; on spi_done it SHALL capture spi_data_received into rx_data and pulse rx_valid[g] on the next cycle.
REQ-022 On spi_done with the latched last=1, the next state SHALL be RELEASE.
REQ-023 On spi_done with last=0 and req[g]=1, the next state SHALL be ISSUE (back-to-back bytes, CS held).
REQ-024 On spi_done with last=0 and req[g]=0, the next state SHALL be ABORT.
REQ-025 ABORT SHALL pulse spi_start with spi_data=8'h00 and spi_hold_cs=0, SHALL pulse err, SHALL NOT pulse tx_ready, then SHALL go to WAIT with last=1.
REQ-026 rx_valid SHALL be suppressed for the byte issued by ABORT.
REQ-027 If the WAIT counter reaches TIMEOUT_CYCLES-1 without spi_done, the block SHALL pulse err, suppress rx_valid, and go to RELEASE.
REQ-028 The WAIT counter SHALL be 16 bits, SHALL clear on entry to WAIT, and SHALL never wrap.
REQ-029 RELEASE SHALL last 1 cycle: grant goes to 0 on exit and the pointer is set to the other requester.
REQ-030 No new grant SHALL occur in the same cycle as RELEASE.
REQ-031 spi_done outside WAIT SHALL be ignored; req changes of the non-owner SHALL be ignored until IDLE.
REQ-032 Minimum spacing between spi_start pulses SHALL be 2 cycles; at most one spi_start SHALL occur per spi_done.

Reset
REQ-033 While rst=1 at a clock edge, the block SHALL load state IDLE, pointer=0, counter=0, grant=0, tx_ready=0, rx_valid=0, rx_data=8'h00, err=0, spi_start=0, spi_data=8'h00, spi_hold_cs=0.
REQ-034 Reset mid-transaction SHALL abandon the transfer without emitting an ABORT byte or err.

Verification
REQ-035 Single byte: req=01, tx_data0=8'hA5, tx_last=01; controller model returns 8'h3C -> one spi_start, spi_hold_cs=0, rx_valid=01 with rx_data=8'h3C, grant=00 after RELEASE.
REQ-036 Contention: req=11 from reset -> requester 0 is served first, then requester 1; with req=11 held, grants alternate 01,10,01.
REQ-037 Three-byte burst for requester 1: bytes 11,22,33, last on the third -> spi_hold_cs sequence 1,1,0, three rx_valid=10 pulses, no gap state besides WAIT/ISSUE.
REQ-038 Abort: requester 0 drops req after the first of two bytes -> spi_data=8'h00 with hold_cs=0, err pulses once, only one rx_valid.
REQ-039 Timeout with TIMEOUT_CYCLES=8 and spi_done never asserted -> err pulses 8 cycles after WAIT entry, grant returns to 00, pointer advances.
REQ-040 rst asserted during WAIT -> all outputs take the REQ-033 values on the next cycle, with no err.
